// File: rtl/clk_switch_pkg.sv
`default_nettype none
// ============================================================================
// clk_switch_pkg : state encoding and default parameters for clk_switch_ctrl
// Revision 1.0
// ============================================================================
package clk_switch_pkg;

  localparam int c_num_req_def       = 4;
  localparam int c_num_select_def    = 2;
  localparam int c_gate_cycles_def   = 2;
  localparam int c_settle_cycles_def = 8;
  localparam int c_reset_sel_def     = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_GATE_OFF = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_switch_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot grant, priority starts at ptr_i
// Revision 1.0
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_hi_lsb;
  logic [NUM_REQ-1:0] w_lo_lsb;

  for (genvar j = 0; j < NUM_REQ; j++) begin : g_mask
    assign w_mask[j] = (PW'(j) >= ptr_i);
  end

  // Lowest set bit at or above the pointer wins; otherwise wrap to the lowest overall.
  assign w_hi     = req_i & w_mask;
  assign w_hi_lsb = w_hi & (-w_hi);
  assign w_lo_lsb = req_i & (-req_i);
  assign grant_o  = (|w_hi) ? w_hi_lsb : w_lo_lsb;

endmodule
`default_nettype wire

// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// clk_switch_ctrl : arbitrated glitch-safe clock source switch controller
// Revision 1.0
// ============================================================================
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter  int NUM_REQ       = c_num_req_def,
  parameter  int NUM_SELECT    = c_num_select_def,
  parameter  int GATE_CYCLES   = c_gate_cycles_def,
  parameter  int SETTLE_CYCLES = c_settle_cycles_def,
  parameter  int RESET_SEL     = c_reset_sel_def,
  localparam int SW            = (NUM_SELECT > 2) ? $clog2(NUM_SELECT) : 1
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*SW-1:0] src_i,
  output logic [SW-1:0]         sel_o,
  output logic                  clk_en_o,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int c_pw         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_gate_eff   = (GATE_CYCLES < 1) ? 1 : GATE_CYCLES;
  localparam int c_settle_eff = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int c_cnt_max    = max_int(c_gate_eff, c_settle_eff);
  localparam int c_cw         = $clog2(c_cnt_max + 1);

  localparam logic [c_cw-1:0] c_gate_load   = c_gate_eff[c_cw-1:0];
  localparam logic [c_cw-1:0] c_settle_load = c_settle_eff[c_cw-1:0];
  localparam logic [c_cw-1:0] c_cnt_one     = 1;
  localparam logic [c_pw-1:0] c_ptr_one     = 1;
  localparam logic [c_pw-1:0] c_ptr_last    = c_pw'(NUM_REQ - 1);
  localparam logic [SW:0]     c_num_sel     = NUM_SELECT[SW:0];
  localparam logic [SW-1:0]   c_reset_sel   = RESET_SEL[SW-1:0];

  state_e               r_state;
  state_e               w_next;
  logic [c_cw-1:0]      r_cnt;
  logic [c_pw-1:0]      r_ptr;
  logic [c_pw-1:0]      r_win_idx;
  logic [NUM_REQ-1:0]   r_grant;
  logic [SW-1:0]        r_src;
  logic                 r_err;
  logic                 r_has_win;
  logic [SW-1:0]        r_sel;
  logic                 r_clk_en;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_err_o;

  logic [NUM_REQ-1:0]   w_grant;
  logic [c_pw-1:0]      w_win_idx;
  logic [SW-1:0]        w_win_src;
  logic                 w_win_bad;
  logic                 w_clk_en_nxt;
  logic [NUM_REQ-1:0]   w_ack_nxt;
  logic                 w_err_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (r_ptr),
    .grant_o (w_grant)
  );

  always_comb begin
    w_win_idx = '0;
    w_win_src = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_grant[r]) begin
        w_win_idx = c_pw'(r);
        w_win_src = src_i[r*SW +: SW];
      end
    end
  end

  assign w_win_bad = ({1'b0, w_win_src} >= c_num_sel);

  // Reset parks the FSM in SETTLE so the boot path reuses the normal settle/DONE sequence.
  always_ff @(posedge clk_i) begin
    if (srst_i) r_state <= ST_SETTLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (|req_i) w_next = ST_ARB;
      ST_ARB: begin
        if (!(|w_grant))                            w_next = ST_IDLE;
        else if (w_win_bad || (w_win_src == r_sel)) w_next = ST_DONE;
        else                                        w_next = ST_GATE_OFF;
      end
      ST_GATE_OFF: if (r_cnt <= c_cnt_one) w_next = ST_SWITCH;
      ST_SWITCH:   w_next = ST_SETTLE;
      ST_SETTLE:   if (r_cnt <= c_cnt_one) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clk_en_nxt = (w_next == ST_IDLE) || (w_next == ST_ARB) || (w_next == ST_DONE);
    w_ack_nxt    = '0;
    w_err_nxt    = 1'b0;
    if (w_next == ST_DONE) begin
      if (r_state == ST_ARB) begin
        w_ack_nxt = w_grant;
        w_err_nxt = w_win_bad;
      end else if (r_has_win) begin
        w_ack_nxt = r_grant;
        w_err_nxt = r_err;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt <= c_settle_load;
    end else if (r_state == ST_ARB && w_next == ST_GATE_OFF) begin
      r_cnt <= c_gate_load;
    end else if (r_state == ST_SWITCH) begin
      r_cnt <= c_settle_load;
    end else if ((r_state == ST_GATE_OFF || r_state == ST_SETTLE) && r_cnt > c_cnt_one) begin
      r_cnt <= r_cnt - c_cnt_one;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_ptr     <= '0;
      r_win_idx <= '0;
      r_grant   <= '0;
      r_src     <= '0;
      r_err     <= 1'b0;
      r_has_win <= 1'b0;
      r_sel     <= c_reset_sel;
    end else begin
      if (r_state == ST_ARB) begin
        r_win_idx <= w_win_idx;
        r_grant   <= w_grant;
        r_src     <= w_win_src;
        r_err     <= w_win_bad;
        r_has_win <= |w_grant;
      end
      if (r_state == ST_SWITCH) r_sel <= r_src;
      if (r_state == ST_DONE) begin
        if (r_has_win) r_ptr <= (r_win_idx == c_ptr_last) ? '0 : r_win_idx + c_ptr_one;
        r_has_win <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_clk_en <= 1'b0;
      r_ack    <= '0;
      r_err_o  <= 1'b0;
    end else begin
      r_clk_en <= w_clk_en_nxt;
      r_ack    <= w_ack_nxt;
      r_err_o  <= w_err_nxt;
    end
  end

  assign sel_o    = r_sel;
  assign clk_en_o = r_clk_en;
  assign ack_o    = r_ack;
  assign err_o    = r_err_o;
  assign busy_o   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_clk_switch_ctrl : directed self-checking bench for clk_switch_ctrl
// Revision 1.0
// ============================================================================
module tb_clk_switch_ctrl;

  logic       clk;
  logic       srst;
  logic [3:0] req;
  logic [3:0] src;
  logic [0:0] sel;
  logic       clk_en;
  logic [3:0] ack;
  logic       err;
  logic       busy;

  logic [3:0] req3;
  logic [7:0] src3;
  logic [1:0] sel3;
  logic       clk_en3;
  logic [3:0] ack3;
  logic       err3;
  logic       busy3;

  int n_tot = 0;
  int n_bad = 0;
  int n_ack = 0;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [0:0] prev_sel;
  logic       prev_en;

  clk_switch_ctrl u_dut (
    .clk_i    (clk),
    .srst_i   (srst),
    .req_i    (req),
    .src_i    (src),
    .sel_o    (sel),
    .clk_en_o (clk_en),
    .ack_o    (ack),
    .err_o    (err),
    .busy_o   (busy)
  );

  clk_switch_ctrl #(
    .NUM_SELECT (3)
  ) u_dut3 (
    .clk_i    (clk),
    .srst_i   (srst),
    .req_i    (req3),
    .src_i    (src3),
    .sel_o    (sel3),
    .clk_en_o (clk_en3),
    .ack_o    (ack3),
    .err_o    (err3),
    .busy_o   (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    srst = 1'b1;
    req  = '0;
    src  = '0;
    req3 = '0;
    src3 = '0;

    // boot: 8 settle cycles with the gate closed, then DONE without ack
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("boot_en c%0d", c), clk_en, (c >= 8));
      chk($sformatf("boot_sel c%0d", c), sel, 0);
      chk($sformatf("boot_ack c%0d", c), ack, 0);
      chk($sformatf("boot_busy c%0d", c), busy, (c <= 8));
      if (c == 8) chk("boot_en3", clk_en3, 1);
    end

    // requester 1 switches to source 1
    @(posedge clk); #1;
    req = 4'b0010;
    src = 4'b0010;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("sw_en c%0d", c), clk_en, (c < 2 || c >= 13));
      chk($sformatf("sw_sel c%0d", c), sel, (c >= 5));
      chk($sformatf("sw_ack c%0d", c), ack, (c == 13) ? 4'b0010 : 4'b0000);
      chk($sformatf("sw_busy c%0d", c), busy, (c >= 1 && c <= 13));
      if (c == 13) req = '0;
    end

    // requester 2 asks for the already selected source
    @(posedge clk); #1;
    req = 4'b0100;
    src = 4'b0100;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("ns_ack c%0d", c), ack, (c == 2) ? 4'b0100 : 4'b0000);
      chk($sformatf("ns_en c%0d", c), clk_en, 1);
      chk($sformatf("ns_sel c%0d", c), sel, 1);
      chk($sformatf("ns_err c%0d", c), err, 0);
      if (c == 2) req = '0;
    end

    // invalid source on the 3-source instance
    @(posedge clk); #1;
    req3 = 4'b0001;
    src3 = 8'h03;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("inv_ack c%0d", c), ack3, (c == 2) ? 4'b0001 : 4'b0000);
      chk($sformatf("inv_err c%0d", c), err3, (c == 2));
      chk($sformatf("inv_sel c%0d", c), sel3, 0);
      chk($sformatf("inv_en c%0d", c), clk_en3, 1);
      if (c == 2) req3 = '0;
    end

    // requester 3 switches back to source 0 and drops its request early
    @(posedge clk); #1;
    req = 4'b1000;
    src = 4'b0000;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("drop_sel c%0d", c), sel, (c < 5));
      chk($sformatf("drop_ack c%0d", c), ack, (c == 13) ? 4'b1000 : 4'b0000);
      chk($sformatf("drop_en c%0d", c), clk_en, (c < 2 || c >= 13));
      if (c == 3) req = '0;
    end

    // reset lands in SETTLE after sel already moved to 1
    @(posedge clk); #1;
    req = 4'b0001;
    src = 4'b0001;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("rs_sel c%0d", c), sel, (c >= 5));
      chk($sformatf("rs_en c%0d", c), clk_en, (c < 2));
    end
    srst = 1'b1;
    req  = '0;
    @(posedge clk); #1;
    srst = 1'b0;
    for (int b = 0; b <= 9; b++) begin
      @(negedge clk);
      chk($sformatf("rs_boot_sel b%0d", b), sel, 0);
      chk($sformatf("rs_boot_ack b%0d", b), ack, 0);
      chk($sformatf("rs_boot_en b%0d", b), clk_en, (b >= 8));
      chk($sformatf("rs_boot_busy b%0d", b), busy, (b <= 8));
    end

    // all four requesters held with alternating targets
    @(posedge clk); #1;
    req = 4'b1111;
    src = 4'b0101;
    prev_sel = sel;
    prev_en  = clk_en;
    for (int c = 0; c < 200 && n_ack < 5; c++) begin
      @(negedge clk);
      if (sel !== prev_sel) chk($sformatf("rr_sel_gate c%0d", c), {prev_en, clk_en}, 2'b00);
      if (ack != 4'b0000) begin
        chk($sformatf("rr_ack%0d", n_ack), ack, 4'b0001 << exp_order[n_ack]);
        n_ack++;
      end
      prev_sel = sel;
      prev_en  = clk_en;
    end
    req = '0;
    chk("rr_count", n_ack, 5);
    repeat (2) @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_en", clk_en, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter NUM_SELECT, default 2: number of selectable clock sources.
REQ-003 SHALL have parameter GATE_CYCLES, default 2: cycles the output gate is held off before the select changes.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8: cycles waited after a select change before the gate reopens.
REQ-005 SHALL have parameter RESET_SEL, default 0: clock source selected out of reset.
REQ-006 SHALL define SW = max(1, $clog2(NUM_SELECT)).
REQ-007 clk_i  input  1  controller clock; one clock only.
REQ-008 srst_i  input  1  reset, synchronous, active-high.
REQ-009 req_i  input  NUM_REQ  per-requester switch request, level, held until ack.
REQ-010 src_i  input  NUM_REQ*SW  per-requester target source, packed, requester r at [r*SW +: SW].
REQ-011 sel_o  output  SW  registered source select to the clock mux.
REQ-012 clk_en_o  output  1  registered gate enable for the selected clock.
REQ-013 ack_o  output  NUM_REQ  one-cycle completion pulse to the winning requester.
REQ-014 err_o  output  1  one-cycle pulse coincident with ack_o when the request was invalid.
REQ-015 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ARB, GATE_OFF, SWITCH, SETTLE, DONE.
REQ-017 IDLE: any req_i high at cycle t -> ARB at t+1; otherwise stay in IDLE.
REQ-018 ARB SHALL pick one winner round-robin, starting from the requester after the last winner, and latch the winner index and its src.
REQ-019 ARB: if src >= NUM_SELECT -> DONE with err flagged; else if src == sel_o -> DONE (no switch); else -> GATE_OFF.
REQ-020 GATE_OFF: clk_en_o low from entry; stay for exactly GATE_CYCLES cycles, then SWITCH.
REQ-021 SWITCH: one cycle; sel_o loads the latched src, visible next cycle; -> SETTLE.
REQ-022 SETTLE: clk_en_o low; down-counter runs exactly SETTLE_CYCLES cycles, then -> DONE.
REQ-023 DONE: one cycle; clk_en_o high; ack_o[winner] pulses; err_o pulses if flagged; round-robin pointer advances past the winner; -> IDLE.
REQ-024 Latency SHALL be measured from req_i sampled in IDLE at cycle 0: switching ack at cycle 3+GATE_CYCLES+SETTLE_CYCLES; no-switch or invalid ack at cycle 2.
REQ-025 sel_o SHALL change only on the SWITCH->SETTLE edge, never while clk_en_o is high.
REQ-026 clk_en_o SHALL never be high in GATE_OFF, SWITCH or SETTLE.
REQ-027 req_i and src_i SHALL be ignored outside IDLE and ARB; arrivals there wait for the next IDLE.
REQ-028 A winner dropping req_i before ack: the operation completes and ack_o is still pulsed.
REQ-029 Simultaneous requests SHALL be served one per transaction, with no requester starved beyond NUM_REQ-1 transactions.
REQ-030 A requester still asserting req_i in the cycle after its ack SHALL be treated as a new request.
REQ-031 Counters SHALL be sized to hold max(GATE_CYCLES, SETTLE_CYCLES) without wrap.
REQ-032 A parameter value of 0 for GATE_CYCLES or SETTLE_CYCLES SHALL be treated as 1.

Reset
REQ-033 On srst_i high: sel_o=RESET_SEL, clk_en_o=0, ack_o=0, err_o=0, busy_o=1, RR pointer=0, state=SETTLE with counter=SETTLE_CYCLES.
REQ-034 After srst_i deasserts, clk_en_o SHALL rise after SETTLE_CYCLES cycles via DONE, with no ack; then IDLE.
REQ-035 srst_i mid-operation SHALL abort the operation with no ack and apply REQ-033, including sel_o reverting to RESET_SEL.

Structure
REQ-036 Package clk_switch_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-037 Round-robin selection SHALL be a separate sub-module rr_arbiter (req vector, pointer in, one-hot grant out); the FSM and counters stay in clk_switch_ctrl.

Verification
REQ-038 Reset release, no requests -> clk_en_o=0 for 8 cycles, then 1; sel_o=0 throughout; no ack.
REQ-039 req_i[1]=1, src=1, from IDLE at cycle 0 -> clk_en_o low from cycle 2; sel_o=1 at cycle 5; ack_o[1] and clk_en_o high at cycle 13.
REQ-040 req_i[2]=1, src=current sel_o -> ack_o[2] at cycle 2; clk_en_o stays 1; sel_o unchanged.
REQ-041 NUM_SELECT=3, src=3 -> ack_o and err_o together at cycle 2; sel_o unchanged.
REQ-042 req_i=4'b1111 held, alternating src -> acks in order 0,1,2,3,0; sel_o never changes while clk_en_o=1.
REQ-043 srst_i asserted during SETTLE -> no ack; sel_o=RESET_SEL next cycle; boot settle restarts.
